// File: rtl/conv_relu_pool_stream.sv
// Streaming conv post-processor: rounding shift, ReLU, saturation and 2x2/stride-2 max-pool.
// Define CONV_POOL_EN to enable pooling; otherwise every accepted beat is emitted directly.
module conv_relu_pool_stream #(
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int IMG_W      = 27,
    parameter int IMG_H      = 27,
    parameter int CH         = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic signed [ACC_W:0] ROUND   = (ACC_W + 1)'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};

    logic [CH_W-1:0]   ch_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic              accept, emit, last;
    logic              ch_last, col_last, row_last;
    logic signed [ACC_W:0] biased, shifted;
    logic [OUT_W-1:0]  relu, res;

    assign in_ready = out_ready || !out_valid;
    assign accept   = in_valid && in_ready;
    assign ch_last  = ch_cnt == CH_W'(CH - 1);
    assign col_last = col_cnt == COL_W'(IMG_W - 1);
    assign row_last = row_cnt == ROW_W'(IMG_H - 1);

    always_comb begin
        biased  = $signed({in_data[ACC_W-1], in_data}) + ROUND;
        shifted = biased >>> FRAC_SHIFT;
        if (shifted < 0) begin
            relu = '0;
        end else if (shifted > SAT_MAX) begin
            relu = {1'b0, {(OUT_W - 1){1'b1}}};
        end else begin
            relu = shifted[OUT_W-1:0];
        end
    end

`ifdef CONV_POOL_EN
    localparam int LB_N = (IMG_W / 2) * CH;
    localparam int LB_W = (LB_N > 1) ? $clog2(LB_N) : 1;

    logic [OUT_W-1:0] col_buf  [CH];
    logic [OUT_W-1:0] line_buf [LB_N];
    logic [LB_W-1:0]  lb_idx;
    logic [OUT_W-1:0] cb, lb, h;
    logic             col_even, row_even, in_col, in_row;

    always_comb begin
        col_even = ~col_cnt[0];
        row_even = ~row_cnt[0];
        // Trailing odd column/row fall outside these windows and are dropped.
        in_col   = col_cnt < COL_W'(2 * (IMG_W / 2));
        in_row   = row_cnt < ROW_W'(2 * (IMG_H / 2));
        lb_idx   = LB_W'(int'(col_cnt >> 1) * CH + int'(ch_cnt));
        cb       = col_buf[ch_cnt];
        lb       = line_buf[lb_idx];
        h        = (cb > relu) ? cb : relu;
        res      = (lb > h) ? lb : h;
        emit     = accept && in_row && in_col && !col_even && !row_even;
        last     = (row_cnt == ROW_W'(2 * (IMG_H / 2) - 1)) &&
                   (col_cnt == COL_W'(2 * (IMG_W / 2) - 1)) && ch_last;
    end

    always_ff @(posedge clk) begin
        if (accept && in_row && in_col) begin
            if (col_even) begin
                col_buf[ch_cnt] <= relu;
            end else if (row_even) begin
                line_buf[lb_idx] <= h;
            end
        end
    end
`else
    always_comb begin
        emit = accept;
        res  = relu;
        last = ch_last && col_last && row_last;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (ch_last) begin
                ch_cnt <= '0;
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end else begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/conv_relu_pool_stream.md
Name: conv_relu_pool_stream

Overview:
- Streaming post-processor for a convolution layer. Accepts raw accumulator outputs in raster order, channel fastest, then column, then row.
- Applies rounding right-shift, ReLU and signed saturation, then 2x2/stride-2 max-pooling per channel, e.g. 27x27xCH in, 13x13xCH out.
- Sits between the conv MAC array and the next layer's input buffer.
- Valid/ready handshake on both sides; one element per cycle peak throughput.

Parameters:
- ACC_W, 32, signed accumulator input width
- OUT_W, 16, signed output width
- FRAC_SHIFT, 8, right-shift applied before saturation (>=1)
- IMG_W, 27, input columns
- IMG_H, 27, input rows
- CH, 256, channels per pixel

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input element valid
- in_ready  output  1  block accepts input element this cycle
- in_data  input  ACC_W  signed accumulator value
- out_valid  output  1  output element valid
- out_ready  input  1  downstream accepts output
- out_data  output  OUT_W  signed result, always >= 0
- out_last  output  1  final element of the output frame

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). On reset, out_valid=0, out_data=0, out_last=0, and all counters (ch_cnt, col_cnt, row_cnt) = 0. Buffer RAM contents are not reset and are don't-care. Reset mid-frame abandons the frame; the next accepted beat is row 0, col 0, ch 0.
- Handshake: transfer when valid&&ready. in_ready = out_ready || !out_valid, for every beat whether or not it produces output. out_data and out_last hold stable while out_valid && !out_ready.
- Arithmetic, same cycle as acceptance:
  - r = (in_data + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed at ACC_W+1 bits, no overflow.
  - If r<0 then r=0; if r>2^(OUT_W-1)-1 then r=2^(OUT_W-1)-1.
- Counters advance on each accepted beat. ch_cnt wraps at CH-1 and increments col_cnt. col_cnt wraps at IMG_W-1 and increments row_cnt. row_cnt wraps at IMG_H-1, so frames run back-to-back.
- Pooling, with k=col_cnt>>1:
  - Even col, col < 2*(IMG_W/2): write r to col_buf[ch].
  - Odd col: h = max(col_buf[ch], r).
    - Even row: write h to line_buf[k][ch].
    - Odd row: output max(line_buf[k][ch], h).
  - col_buf is CH x OUT_W; line_buf is (IMG_W/2)*CH x OUT_W.
  - Odd trailing column (col = IMG_W-1 when IMG_W odd) and odd trailing row (row = IMG_H-1 when IMG_H odd) are accepted and discarded, no output.
- Latency: an emitting input beat accepted at cycle t produces out_valid=1 at t+1. Non-emitting beats never assert out_valid.
- Output register: load on emitting beat; clear out_valid on out_ready with no new load. Simultaneous pop and load in the same cycle is allowed.
- out_last=1 with the output for row 2*(IMG_H/2)-1, col 2*(IMG_W/2)-1, ch CH-1; otherwise 0.
- Output count per frame = (IMG_W/2)*(IMG_H/2)*CH. Output order: channel fastest, then pooled column, then pooled row.

Optional Feature:
- CONV_POOL_EN defined: pooling as above. Buffers are instantiated.
- CONV_POOL_EN undefined: no buffers; every accepted beat emits its ReLU/saturated value at t+1. Output count = IMG_W*IMG_H*CH, and out_last marks the last input element of the frame. Handshake, arithmetic and reset are identical.

Test Plan (IMG_W=5, IMG_H=5, CH=2, FRAC_SHIFT=8, OUT_W=16, pooled unless stated):
- Arithmetic: in_data -256 -> 0; 383 -> 1; 384 -> 2; 0x7FFFFFFF -> 32767 (pool disabled, single beats).
- Pooling: ch0 pixel value = (row*5+col)<<8, ch1 = 100<<8 constant. Expect 8 outputs: 6,100,8,100,16,100,18,100. out_last on the 8th only. Col 4 and row 4 produce nothing.
- Backpressure: out_ready held 0 for 5 cycles when the first output is pending -> out_data stable, in_ready=0, no element lost or duplicated, order unchanged.
- Back-to-back frames with in_valid=1 and out_ready=1 continuous -> second frame outputs identical to first; counters wrap with no gap.
- Reset mid-frame: assert rst_n=0 after 13 beats -> out_valid=0 immediately. Fresh frame after release yields the same 8 outputs as the pooling test.
- CONV_POOL_EN undefined: 50-beat frame -> 50 outputs, each equal to the transformed input of the previous accepted cycle; out_last on beat 50.
